// File: rtl/store_buffer_pkg.sv
// Shared memory-path definitions for the store buffer: word/address widths
// and the byte-address to word-index helper.
package store_buffer_pkg;

   localparam int WORD_W  = 16;
   localparam int WADDR_W = 15;

   // Word index of a 16-bit byte address (drops the byte-select bit).
   function automatic logic [WADDR_W-1:0] word_idx(input logic [WORD_W-1:0] addr);
      return WADDR_W'(addr >> 1);
   endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Bus bundle between the CPU load/store path, the store buffer and DMemBank.
//
// Handshakes:
//  - Store: cpu_memwrite is "valid", !cpu_stall is "ready". A store transfers
//    on the rising edge where cpu_memwrite=1 and cpu_stall=0; while stalled the
//    CPU holds every cpu_* input unchanged.
//  - Memory write: mem_memwrite is "valid", !mem_busy is "ready". The buffer
//    only raises mem_memwrite when mem_busy is low, so every asserted
//    mem_memwrite is committed by DMemBank at the next rising edge.
//  - Load: cpu_memread is a single-cycle request answered combinationally on
//    cpu_readdata; it owns the memory port for that cycle.
interface store_buffer_if import store_buffer_pkg::*; ();

   logic              cpu_memread;
   logic              cpu_memwrite;
   logic [WORD_W-1:0] cpu_address;
   logic [WORD_W-1:0] cpu_writedata;
   logic [WORD_W-1:0] cpu_readdata;
   logic              cpu_stall;
   logic              mem_memread;
   logic              mem_memwrite;
   logic [WORD_W-1:0] mem_address;
   logic [WORD_W-1:0] mem_writedata;
   logic [WORD_W-1:0] mem_readdata;
   logic              mem_busy;
   logic              sb_empty;

   // Store buffer side.
   modport slave (
      input  cpu_memread, cpu_memwrite, cpu_address, cpu_writedata,
      input  mem_readdata, mem_busy,
      output cpu_readdata, cpu_stall,
      output mem_memread, mem_memwrite, mem_address, mem_writedata,
      output sb_empty
   );

   // Environment side (CPU plus DMemBank).
   modport master (
      output cpu_memread, cpu_memwrite, cpu_address, cpu_writedata,
      output mem_readdata, mem_busy,
      input  cpu_readdata, cpu_stall,
      input  mem_memread, mem_memwrite, mem_address, mem_writedata,
      input  sb_empty
   );

endinterface

// File: rtl/store_buffer_fwd_match.sv
// Youngest-match search over the store buffer entries. Entries are ordered by
// age relative to wr_ptr: wr_ptr-1 is the youngest, wr_ptr-DEPTH the oldest.
module store_buffer_fwd_match import store_buffer_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic [DEPTH-1:0]              valid,
   input  logic [DEPTH-1:0][WADDR_W-1:0] addr,
   input  logic [WADDR_W-1:0]            key,
   input  logic [PTR_W-1:0]              wr_ptr,
   output logic                          hit,
   output logic [PTR_W-1:0]              hit_idx
);

   // Walk from oldest to youngest so the last matching entry (youngest) wins.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (valid[wr_ptr - PTR_W'(k)] && (addr[wr_ptr - PTR_W'(k)] == key)) begin
            hit     = 1'b1;
            hit_idx = wr_ptr - PTR_W'(k);
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the CPU load/store path and the data memory.
// Stores retire into the buffer in one cycle and drain one per cycle to the
// memory write port when it is free; loads forward from the youngest matching
// pending store or fall through to memory.
module store_buffer import store_buffer_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input logic           clk,
   input logic           rst,
   store_buffer_if.slave bus
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   // FIFO storage and bookkeeping.
   logic [DEPTH-1:0][WADDR_W-1:0] addr_q,  addr_d;
   logic [DEPTH-1:0][WORD_W-1:0]  data_q,  data_d;
   logic [DEPTH-1:0]              valid_q, valid_d;
   logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]                count_q, count_d;

   logic empty;
   logic full;
   logic drain;
   logic stall;
   logic enq;
   logic fwd_hit;
   logic [PTR_W-1:0] fwd_idx;

   store_buffer_fwd_match #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fwd_match (
      .valid   (valid_q),
      .addr    (addr_q),
      .key     (word_idx(bus.cpu_address)),
      .wr_ptr  (wr_ptr_q),
      .hit     (fwd_hit),
      .hit_idx (fwd_idx)
   );

   // Port arbitration: a load owns the memory port, otherwise the oldest entry
   // drains whenever memory can take it. A store only stalls when the buffer
   // is full and no slot frees up this same cycle.
   always_comb begin
      empty = (count_q == '0);
      full  = (count_q == FULL_CNT);
      drain = !empty && !bus.cpu_memread && !bus.mem_busy;
      stall = bus.cpu_memwrite && full && !drain;
      enq   = bus.cpu_memwrite && !stall;
   end

   // Memory-side and CPU-side outputs.
   always_comb begin
      bus.cpu_stall     = stall;
      bus.sb_empty      = empty;
      bus.mem_memread   = bus.cpu_memread;
      bus.mem_memwrite  = drain;
      bus.mem_address   = '0;
      bus.mem_writedata = '0;
      bus.cpu_readdata  = '0;
      if (bus.cpu_memread) begin
         bus.mem_address = bus.cpu_address;
      end else if (drain) begin
         bus.mem_address   = {addr_q[rd_ptr_q], 1'b0};
         bus.mem_writedata = data_q[rd_ptr_q];
      end
      if (bus.cpu_memread) begin
         bus.cpu_readdata = fwd_hit ? data_q[fwd_idx] : bus.mem_readdata;
      end
   end

   // Next FIFO state: dequeue first so a full buffer can enqueue into the
   // slot being drained in the same cycle.
   always_comb begin
      addr_d   = addr_q;
      data_d   = data_q;
      valid_d  = valid_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (drain) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + 1'b1;
      end
      if (enq) begin
         addr_d[wr_ptr_q]  = word_idx(bus.cpu_address);
         data_d[wr_ptr_q]  = bus.cpu_writedata;
         valid_d[wr_ptr_q] = 1'b1;
         wr_ptr_d          = wr_ptr_q + 1'b1;
      end
      case ({enq, drain})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO registers; reset discards every pending store.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q   <= '0;
         data_q   <= '0;
         valid_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         addr_q   <= addr_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small behavioural DMemBank.
module tb_store_buffer;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   store_buffer_if bus ();

   store_buffer #(
      .DEPTH (4),
      .PTR_W (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DMemBank model ----------------
   logic [15:0] mem [0:255] = '{default: 16'h0000};
   logic [31:0] wr_log[$];
   logic [31:0] exp_q[$];

   assign bus.mem_readdata = bus.mem_memread ? mem[bus.mem_address[8:1]] : 16'h0000;

   always @(posedge clk) begin
      if (bus.mem_memwrite) begin
         mem[bus.mem_address[8:1]] <= bus.mem_writedata;
         wr_log.push_back({bus.mem_address, bus.mem_writedata});
      end
   end

   // Load and store in the same cycle is illegal.
   always @(negedge clk) begin
      if (!rst) begin
         assert (!(bus.cpu_memread && bus.cpu_memwrite)) else begin
            bad++;
            $display("FAIL ld_st_overlap observed=1 expected=0");
            $error("load and store together");
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      bus.cpu_memread   = 1'b0;
      bus.cpu_memwrite  = 1'b0;
      bus.cpu_address   = 16'h0000;
      bus.cpu_writedata = 16'h0000;
   endtask

   task automatic store(input logic [15:0] a, input logic [15:0] d);
      bus.cpu_memread   = 1'b0;
      bus.cpu_memwrite  = 1'b1;
      bus.cpu_address   = a;
      bus.cpu_writedata = d;
   endtask

   task automatic load(input logic [15:0] a);
      bus.cpu_memwrite  = 1'b0;
      bus.cpu_memread   = 1'b1;
      bus.cpu_address   = a;
      bus.cpu_writedata = 16'h0000;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b1;
      bus.mem_busy = 1'b0;
      idle();
      #2;
      chk("rst_empty",   32'(bus.sb_empty), 32'h1);
      chk("rst_stall",   32'(bus.cpu_stall), 32'h0);
      chk("rst_memwr",   32'(bus.mem_memwrite), 32'h0);
      chk("rst_memrd",   32'(bus.mem_memread), 32'h0);
      chk("rst_rdata",   32'(bus.cpu_readdata), 32'h0);
      tick();
      tick();
      rst = 1'b0;

      // 1: store, drain next cycle, load back from memory.
      store(16'h0004, 16'h1234);
      settle();
      chk("t1_stall",  32'(bus.cpu_stall), 32'h0);
      chk("t1_nowr",   32'(bus.mem_memwrite), 32'h0);
      exp_q.push_back({16'h0004, 16'h1234});
      tick();
      idle();
      settle();
      chk("t1_drain_wr",   32'(bus.mem_memwrite), 32'h1);
      chk("t1_drain_addr", 32'(bus.mem_address), 32'h0004);
      chk("t1_drain_data", 32'(bus.mem_writedata), 32'h1234);
      chk("t1_not_empty",  32'(bus.sb_empty), 32'h0);
      tick();
      load(16'h0004);
      settle();
      chk("t1_load",    32'(bus.cpu_readdata), 32'h1234);
      chk("t1_memrd",   32'(bus.mem_memread), 32'h1);
      chk("t1_empty",   32'(bus.sb_empty), 32'h1);
      tick();

      // 2: two stores to the same word while busy; youngest forwarded.
      bus.mem_busy = 1'b1;
      store(16'h0010, 16'hAAAA);
      settle();
      chk("t2_stall", 32'(bus.cpu_stall), 32'h0);
      tick();
      store(16'h0010, 16'hBBBB);
      tick();
      load(16'h0010);
      settle();
      chk("t2_fwd",      32'(bus.cpu_readdata), 32'hBBBB);
      chk("t2_nowr",     32'(bus.mem_memwrite), 32'h0);
      chk("t2_nonempty", 32'(bus.sb_empty), 32'h0);
      tick();
      load(16'h0012);
      settle();
      chk("t2_miss", 32'(bus.cpu_readdata), 32'h0000);
      tick();
      idle();
      bus.mem_busy = 1'b0;
      exp_q.push_back({16'h0010, 16'hAAAA});
      exp_q.push_back({16'h0010, 16'hBBBB});
      settle();
      chk("t2_drain0", 32'(bus.mem_writedata), 32'hAAAA);
      tick();
      settle();
      chk("t2_drain1", 32'(bus.mem_writedata), 32'hBBBB);
      tick();
      settle();
      chk("t2_empty", 32'(bus.sb_empty), 32'h1);
      load(16'h0010);
      settle();
      chk("t2_memval", 32'(bus.cpu_readdata), 32'hBBBB);
      tick();

      // 3: fill while busy, fifth store stalls until busy drops.
      bus.mem_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         store(16'h0020 + 16'(2*i), 16'h3000 + 16'(i));
         settle();
         chk("t3_fill_stall", 32'(bus.cpu_stall), 32'h0);
         exp_q.push_back({16'h0020 + 16'(2*i), 16'h3000 + 16'(i)});
         tick();
      end
      store(16'h0028, 16'h3004);
      settle();
      chk("t3_stall5", 32'(bus.cpu_stall), 32'h1);
      tick();
      settle();
      chk("t3_stall5_hold", 32'(bus.cpu_stall), 32'h1);
      bus.mem_busy = 1'b0;
      settle();
      chk("t3_release_stall", 32'(bus.cpu_stall), 32'h0);
      chk("t3_release_wr",    32'(bus.mem_memwrite), 32'h1);
      chk("t3_release_data",  32'(bus.mem_writedata), 32'h3000);
      exp_q.push_back({16'h0028, 16'h3004});
      tick();
      idle();
      for (int j = 1; j < 5; j++) begin
         settle();
         chk("t3_drain", 32'(bus.mem_writedata), 32'h3000 + 32'(j));
         tick();
      end
      settle();
      chk("t3_empty", 32'(bus.sb_empty), 32'h1);
      load(16'h0028);
      settle();
      chk("t3_mem5", 32'(bus.cpu_readdata), 32'h3004);
      tick();
      load(16'h0020);
      settle();
      chk("t3_mem1", 32'(bus.cpu_readdata), 32'h3000);
      tick();

      // 4: loads hold off draining while two entries pend.
      bus.mem_busy = 1'b1;
      store(16'h0040, 16'h4040);
      tick();
      store(16'h0042, 16'h4242);
      tick();
      bus.mem_busy = 1'b0;
      load(16'h0040);
      settle();
      chk("t4_fwd0",  32'(bus.cpu_readdata), 32'h4040);
      chk("t4_nowr0", 32'(bus.mem_memwrite), 32'h0);
      tick();
      load(16'h0042);
      settle();
      chk("t4_fwd1",  32'(bus.cpu_readdata), 32'h4242);
      chk("t4_nowr1", 32'(bus.mem_memwrite), 32'h0);
      tick();
      load(16'h0044);
      settle();
      chk("t4_miss",  32'(bus.cpu_readdata), 32'h0000);
      chk("t4_nowr2", 32'(bus.mem_memwrite), 32'h0);
      tick();
      idle();
      exp_q.push_back({16'h0040, 16'h4040});
      exp_q.push_back({16'h0042, 16'h4242});
      settle();
      chk("t4_resume0_wr",   32'(bus.mem_memwrite), 32'h1);
      chk("t4_resume0_addr", 32'(bus.mem_address), 32'h0040);
      tick();
      settle();
      chk("t4_resume1_addr", 32'(bus.mem_address), 32'h0042);
      tick();
      settle();
      chk("t4_empty", 32'(bus.sb_empty), 32'h1);
      chk("t4_idle_wr", 32'(bus.mem_memwrite), 32'h0);

      // 5: ten back-to-back store/drain pairs across pointer wrap.
      for (int i = 0; i < 10; i++) begin
         store(16'(2*i), 16'h5000 + 16'(i));
         exp_q.push_back({16'(2*i), 16'h5000 + 16'(i)});
         settle();
         chk("t5_stall", 32'(bus.cpu_stall), 32'h0);
         if (i > 0) chk("t5_drain", 32'(bus.mem_writedata), 32'h5000 + 32'(i - 1));
         tick();
      end
      idle();
      settle();
      chk("t5_last_wr",   32'(bus.mem_memwrite), 32'h1);
      chk("t5_last_data", 32'(bus.mem_writedata), 32'h5009);
      tick();
      for (int i = 0; i < 10; i++) begin
         load(16'(2*i));
         settle();
         chk("t5_mem", 32'(bus.cpu_readdata), 32'h5000 + 32'(i));
         tick();
      end

      // 6: reset with three stores pending discards them.
      idle();
      bus.mem_busy = 1'b1;
      store(16'h0060, 16'h6060);
      tick();
      store(16'h0062, 16'h6262);
      tick();
      store(16'h0064, 16'h6464);
      tick();
      idle();
      settle();
      chk("t6_pending", 32'(bus.sb_empty), 32'h0);
      rst = 1'b1;
      bus.mem_busy = 1'b0;
      settle();
      chk("t6_rst_empty", 32'(bus.sb_empty), 32'h1);
      chk("t6_rst_wr",    32'(bus.mem_memwrite), 32'h0);
      chk("t6_rst_stall", 32'(bus.cpu_stall), 32'h0);
      chk("t6_rst_rdata", 32'(bus.cpu_readdata), 32'h0);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("t6_no_drain", 32'(bus.mem_memwrite), 32'h0);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         load(16'h0060 + 16'(2*i));
         settle();
         chk("t6_mem_clean", 32'(bus.cpu_readdata), 32'h0000);
         tick();
      end
      idle();
      tick();

      // Scoreboard: memory saw every store exactly once, in program order.
      chk("sb_write_count", 32'(wr_log.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && wr_log.size() > 0) begin
         chk("sb_write_order", wr_log.pop_front(), exp_q.pop_front());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
